// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared types and widths for the SRAM-to-UART transmit path.
package uart_sram_tx_interface_pkg;

  localparam int ADDR_W = 18;
  localparam int CNT_W  = 18;
  localparam int DATA_W = 16;
  localparam int BAUD_W = 9;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ_0,
    S_TX_READ_1,
    S_TX_READ_2,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP
  } tx_state_type;

  // The board-level FSM hands SRAM to this block while in S_UART_TX.
  typedef enum logic [1:0] {
    S_TOP_IDLE,
    S_UART_RX,
    S_UART_TX
  } top_state_type;

  function automatic logic [ADDR_W-1:0] next_address(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_if.sv
// Request, SRAM and line signals of the transmit block; slave is the transmitter side.
interface uart_sram_tx_interface_if;
  import uart_sram_tx_interface_pkg::*;

  logic              Start;
  logic [ADDR_W-1:0] Base_address;
  logic [CNT_W-1:0]  Word_count;
  logic [ADDR_W-1:0] SRAM_address;
  logic [DATA_W-1:0] SRAM_read_data;
  logic              SRAM_we_n;
  logic              UART_TX_O;
  logic              Busy;
  logic              Done;

  modport master (
    output Start, Base_address, Word_count, SRAM_read_data,
    input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

  modport slave (
    input  Start, Base_address, Word_count, SRAM_read_data,
    output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

endinterface

// File: rtl/uart_sram_tx_interface_serializer.sv
// 8N1 byte serializer; a load during the final stop cycle chains the next frame with no gap.
module uart_tx_serializer
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       load,
  input  logic [7:0] data,
  output logic       line,
  output logic       bit_end,
  output logic [3:0] bit_pos,
  output logic       frame_done
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        shift_reg;

  assign bit_end    = active && (baud_cnt == BAUD_LAST);
  assign frame_done = bit_end && (bit_pos == 4'd9);

  // bit_pos 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      line      <= 1'b1;
      active    <= 1'b0;
      baud_cnt  <= '0;
      bit_pos   <= '0;
      shift_reg <= '0;
    end else if (load) begin
      line      <= 1'b0;
      active    <= 1'b1;
      baud_cnt  <= '0;
      bit_pos   <= '0;
      shift_reg <= data;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        bit_pos  <= bit_pos + 4'd1;
        if (bit_pos == 4'd9) begin
          active <= 1'b0;
        end else if (bit_pos == 4'd8) begin
          line <= 1'b1;
        end else begin
          line <= shift_reg[bit_pos[2:0]];
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads 16-bit words from SRAM and sends each as two 8N1 frames, high byte first.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input logic                      Clock,
  input logic                      Resetn,
  uart_sram_tx_interface_if.slave  bus
);

  tx_state_type      state;
  logic [CNT_W-1:0]  words_left;
  logic [DATA_W-1:0] word_reg;
  logic              byte_sel;
  logic [ADDR_W-1:0] sram_address;
  logic              busy;
  logic              done;

  logic       ser_load;
  logic [7:0] ser_data;
  logic       ser_line;
  logic       bit_end;
  logic [3:0] bit_pos;
  logic       frame_done;

  // The low byte is loaded at the end of the high byte's stop bit, so the
  // data mux keys off the state rather than byte_sel.
  assign ser_load = (state == S_TX_READ_2) ||
                    ((state == S_TX_STOP) && frame_done && !byte_sel);
  assign ser_data = (state == S_TX_STOP) ? word_reg[7:0] : word_reg[15:8];

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .load       (ser_load),
    .data       (ser_data),
    .line       (ser_line),
    .bit_end    (bit_end),
    .bit_pos    (bit_pos),
    .frame_done (frame_done)
  );

  // SRAM data for the address registered on entry to READ_0 is valid two edges later.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_TX_IDLE;
      words_left   <= '0;
      word_reg     <= '0;
      byte_sel     <= 1'b0;
      sram_address <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_TX_IDLE: begin
          if (bus.Start) begin
            if (bus.Word_count != '0) begin
              words_left   <= bus.Word_count;
              sram_address <= bus.Base_address;
              busy         <= 1'b1;
              state        <= S_TX_READ_0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_TX_READ_0: state <= S_TX_READ_1;
        S_TX_READ_1: begin
          word_reg <= bus.SRAM_read_data;
          byte_sel <= 1'b0;
          state    <= S_TX_READ_2;
        end
        S_TX_READ_2: state <= S_TX_START;
        S_TX_START: begin
          if (bit_end) state <= S_TX_DATA;
        end
        S_TX_DATA: begin
          if (bit_end && (bit_pos == 4'd8)) state <= S_TX_STOP;
        end
        S_TX_STOP: begin
          if (frame_done) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              state    <= S_TX_START;
            end else if (words_left != CNT_W'(1)) begin
              words_left   <= words_left - CNT_W'(1);
              sram_address <= next_address(sram_address);
              state        <= S_TX_READ_0;
            end else begin
              words_left <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= S_TX_IDLE;
            end
          end
        end
        default: state <= S_TX_IDLE;
      endcase
    end
  end

  assign bus.SRAM_address = sram_address;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.UART_TX_O    = ser_line;
  assign bus.Busy         = busy;
  assign bus.Done         = done;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Scoreboard bench: expected frames/Done pulses are queued at stimulus time and checked by a line monitor.
module tb_uart_sram_tx_interface;
  import uart_sram_tx_interface_pkg::*;

  localparam int CLKS  = 4;
  localparam int FRAME = 10 * CLKS;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } frame_t;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  frame_t     exp_q[$];
  int         done_q[$];
  logic [15:0] mem [bit [17:0]];

  uart_sram_tx_interface_if bus();

  uart_sram_tx_interface #(
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Two-cycle SRAM: the address seen at edge k is returned in time for edge k+2.
  always @(posedge Clock) begin
    bus.SRAM_read_data <= mem.exists(bus.SRAM_address) ? mem[bus.SRAM_address] : 16'h0000;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic pushFrame(input logic [7:0] data, input int gap);
    frame_t f;
    f.data = data;
    f.gap  = gap;
    exp_q.push_back(f);
  endtask

  task automatic applyStimulus(input logic [17:0] base, input logic [17:0] count);
    @(negedge Clock);
    bus.Base_address = base;
    bus.Word_count   = count;
    bus.Start        = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge Clock);
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout pending_frames=%0d pending_done=%0d", name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (2) @(negedge Clock);
  endtask

  // Line monitor: decodes frames cycle by cycle, checking every cycle of every bit.
  initial begin : monitor
    int     cyc      = 0;
    int     last_end = -1;
    int     pos      = 0;
    int     slot     = 0;
    int     gap      = 0;
    logic   active   = 1'b0;
    logic   shape_ok = 1'b1;
    logic   cur_bit  = 1'b0;
    logic [7:0] rx   = 8'h00;
    frame_t e;
    forever begin
      @(negedge Clock);
      cyc++;
      if (!Resetn) begin
        active   = 1'b0;
        last_end = -1;
        continue;
      end
      checkOutput("sram_we_n", bus.SRAM_we_n, 1);
      if (!active && bus.UART_TX_O == 1'b0) begin
        active   = 1'b1;
        pos      = 0;
        shape_ok = 1'b1;
        rx       = 8'h00;
        gap      = (last_end < 0) ? -1 : cyc - last_end;
      end
      if (active) begin
        slot = pos / CLKS;
        if (slot == 0) begin
          if (bus.UART_TX_O !== 1'b0) shape_ok = 1'b0;
        end else if (slot == 9) begin
          if (bus.UART_TX_O !== 1'b1) shape_ok = 1'b0;
        end else if (pos % CLKS == 0) begin
          cur_bit       = bus.UART_TX_O;
          rx[slot - 1]  = cur_bit;
        end else if (bus.UART_TX_O !== cur_bit) begin
          shape_ok = 1'b0;
        end
        pos++;
        if (pos == FRAME) begin
          active   = 1'b0;
          last_end = cyc + 1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame actual=%0h required=none", rx);
          end else begin
            e = exp_q.pop_front();
            checkOutput("frame_data", rx, e.data);
            checkOutput("frame_shape", shape_ok, 1);
            if (e.gap >= 0) checkOutput("frame_gap", gap, e.gap);
          end
        end
      end
      if (bus.Done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          void'(done_q.pop_front());
          checkOutput("done_after_frames", exp_q.size(), 0);
          checkOutput("busy_at_done", bus.Busy, 0);
        end
      end
    end
  end

  initial begin
    bus.Start        = 1'b0;
    bus.Base_address = '0;
    bus.Word_count   = '0;

    #12;
    checkOutput("reset_line", bus.UART_TX_O, 1);
    checkOutput("reset_busy", bus.Busy, 0);
    checkOutput("reset_done", bus.Done, 0);
    checkOutput("reset_addr", bus.SRAM_address, 0);
    checkOutput("reset_we_n", bus.SRAM_we_n, 1);
    @(negedge Clock);
    Resetn = 1'b1;

    // One word, high byte first.
    mem[18'h00000] = 16'hA55A;
    pushFrame(8'hA5, -1);
    pushFrame(8'h5A, 0);
    done_q.push_back(1);
    applyStimulus(18'h00000, 18'd1);
    checkOutput("busy_after_start", bus.Busy, 1);
    waitIdle(200, "t1");

    // Empty transfer: Done only, nothing else moves.
    done_q.push_back(2);
    @(negedge Clock);
    bus.Base_address = 18'h00155;
    bus.Word_count   = 18'd0;
    bus.Start        = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
    checkOutput("empty_done", bus.Done, 1);
    checkOutput("empty_busy", bus.Busy, 0);
    checkOutput("empty_line", bus.UART_TX_O, 1);
    checkOutput("empty_addr", bus.SRAM_address, 0);
    @(negedge Clock);
    checkOutput("empty_done_width", bus.Done, 0);
    checkOutput("empty_busy_late", bus.Busy, 0);
    waitIdle(10, "t2");

    // Address wraps from the top of SRAM to zero.
    mem[18'h3FFFF] = 16'h8001;
    mem[18'h00000] = 16'h7E42;
    pushFrame(8'h80, -1);
    pushFrame(8'h01, 0);
    pushFrame(8'h7E, 3);
    pushFrame(8'h42, 0);
    done_q.push_back(3);
    applyStimulus(18'h3FFFF, 18'd2);
    waitIdle(300, "t3");
    checkOutput("wrap_addr", bus.SRAM_address, 18'h00000);

    // A second Start mid-transfer and changing inputs are ignored.
    mem[18'h00010] = 16'hDEAD;
    mem[18'h00011] = 16'hBEEF;
    pushFrame(8'hDE, -1);
    pushFrame(8'hAD, 0);
    pushFrame(8'hBE, 3);
    pushFrame(8'hEF, 0);
    done_q.push_back(4);
    applyStimulus(18'h00010, 18'd2);
    repeat (30) @(negedge Clock);
    bus.Base_address = 18'h00200;
    bus.Word_count   = 18'd5;
    bus.Start        = 1'b1;
    @(negedge Clock);
    bus.Start        = 1'b0;
    bus.Base_address = 18'h00333;
    bus.Word_count   = 18'd7;
    waitIdle(300, "t4");
    checkOutput("ignore_addr", bus.SRAM_address, 18'h00011);

    // Reset in the middle of data bit 3, then a clean transfer.
    mem[18'h00020] = 16'hA55A;
    applyStimulus(18'h00020, 18'd1);
    for (int i = 0; i < 20 && bus.UART_TX_O !== 1'b0; i++) @(negedge Clock);
    checkOutput("abort_start_seen", bus.UART_TX_O, 0);
    repeat (17) @(negedge Clock);
    checkOutput("abort_bit3_before", bus.UART_TX_O, 0);
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("abort_line", bus.UART_TX_O, 1);
    checkOutput("abort_busy", bus.Busy, 0);
    checkOutput("abort_addr", bus.SRAM_address, 0);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    pushFrame(8'hA5, -1);
    pushFrame(8'h5A, 0);
    done_q.push_back(5);
    applyStimulus(18'h00020, 18'd1);
    waitIdle(200, "t5");

    // Three words back to back.
    mem[18'h00100] = 16'h1234;
    mem[18'h00101] = 16'h5678;
    mem[18'h00102] = 16'h9ABC;
    pushFrame(8'h12, -1);
    pushFrame(8'h34, 0);
    pushFrame(8'h56, 3);
    pushFrame(8'h78, 0);
    pushFrame(8'h9A, 3);
    pushFrame(8'hBC, 0);
    done_q.push_back(6);
    applyStimulus(18'h00100, 18'd3);
    waitIdle(400, "t6");
    checkOutput("final_busy", bus.Busy, 0);
    checkOutput("final_line", bus.UART_TX_O, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
